// File: rtl/axis2fib_txwr.sv
// axis2fib_txwr: AXI-Stream slave that writes frame words into the FMAC data FIFO and each frame's byte count into the byte-count FIFO.
//
// Ports:
//   clk_fib, reset_        FMAC-domain clock and asynchronous active-low reset
//   s_axis_*               AXI-Stream slave (tdata/tkeep/tvalid/tlast in, tready out)
//   wrfull_wf, wrusedw_wf  data FIFO status; wr_wf/datain_wf data FIFO write port
//   wrfull_wcf             byte-count FIFO full; wr_wcf/datain_wcf byte-count FIFO write port
//   err_clr                clears the sticky flags err_oversize and err_tkeep
//   frame_cnt, byte_cnt    committed frame/byte statistics
//
// Build option: define AXIS_TXWR_STATS_EN to implement frame_cnt/byte_cnt.
// When it is not defined, both outputs are tied to zero.
module axis2fib_txwr #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          BCNT_WIDTH  = 32,
    parameter logic [15:0] MAX_BYTES   = 16'd9600,
    parameter logic [9:0]  WF_AFULL_TH = 10'd256
) (
    input  logic                    clk_fib,
    input  logic                    reset_,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    wrfull_wf,
    input  logic [9:0]              wrusedw_wf,
    output logic                    wr_wf,
    output logic [DATA_WIDTH-1:0]   datain_wf,
    input  logic                    wrfull_wcf,
    output logic                    wr_wcf,
    output logic [BCNT_WIDTH-1:0]   datain_wcf,
    input  logic                    err_clr,
    output logic                    err_oversize,
    output logic                    err_tkeep,
    output logic [31:0]             frame_cnt,
    output logic [31:0]             byte_cnt
);
    localparam int KW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE = 3'b001, DATA = 3'b010, DISCARD = 3'b100} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx, bc_nx, pc;
    logic [16:0] sum;
    logic        acc, over, keep_ok, wf_nx, wcf_nx, os_set, tk_set;

    // A frame may only start when a byte-count slot and data space are both
    // available; once started, wrfull_wcf is no longer consulted.
    assign s_axis_tready = reset_ & (state == IDLE ? (!wrfull_wcf && !wrfull_wf && wrusedw_wf <= WF_AFULL_TH) :
                                     state == DATA ? !wrfull_wf : state == DISCARD);
    assign acc  = s_axis_tvalid & s_axis_tready;
    assign sum  = {1'b0, cnt} + {1'b0, pc};
    assign over = sum > {1'b0, MAX_BYTES};
    // Last beats must be a contiguous low-byte mask (k & (k+1) == 0); others must be full.
    assign keep_ok = s_axis_tlast ? ((s_axis_tkeep & (s_axis_tkeep + KW'(1))) == '0) : (&s_axis_tkeep);

    always_comb begin
        pc = '0;
        for (int i = 0; i < KW; i++)
            pc = pc + 16'(s_axis_tkeep[i]);
    end

    always_ff @(posedge clk_fib or negedge reset_) begin
        if (!reset_)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bc_nx    = cnt;
        wf_nx    = 1'b0;
        wcf_nx   = 1'b0;
        os_set   = 1'b0;
        tk_set   = acc & !keep_ok;
        case (state)
            IDLE, DATA: begin
                if (acc) begin
                    if (over) begin
                        // Saturate at the bytes already written and drop the beat.
                        os_set   = 1'b1;
                        state_nx = s_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        wf_nx    = |s_axis_tkeep;
                        bc_nx    = sum[15:0];
                        cnt_nx   = sum[15:0];
                        state_nx = s_axis_tlast ? IDLE : DATA;
                    end
                    if (s_axis_tlast) begin
                        cnt_nx = '0;
                        wcf_nx = bc_nx != '0;
                        tk_set = tk_set | (bc_nx == '0);
                    end
                end
            end
            DISCARD: begin
                if (acc && s_axis_tlast) begin
                    cnt_nx   = '0;
                    wcf_nx   = cnt != '0;
                    tk_set   = tk_set | (cnt == '0);
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_fib or negedge reset_) begin
        if (!reset_) begin
            cnt          <= '0;
            wr_wf        <= 1'b0;
            datain_wf    <= '0;
            wr_wcf       <= 1'b0;
            datain_wcf   <= '0;
            err_oversize <= 1'b0;
            err_tkeep    <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            wr_wf  <= wf_nx;
            wr_wcf <= wcf_nx;
            if (wf_nx)
                datain_wf <= s_axis_tdata;
            if (wcf_nx)
                datain_wcf <= BCNT_WIDTH'(bc_nx);
            // A set event in the same cycle as err_clr wins.
            err_oversize <= os_set | (err_oversize & !err_clr);
            err_tkeep    <= tk_set | (err_tkeep & !err_clr);
        end
    end

`ifdef AXIS_TXWR_STATS_EN
    always_ff @(posedge clk_fib or negedge reset_) begin
        if (!reset_) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
        end else if (wcf_nx) begin
            frame_cnt <= frame_cnt + 32'd1;
            byte_cnt  <= byte_cnt + 32'(bc_nx);
        end
    end
`else
    assign frame_cnt = '0;
    assign byte_cnt  = '0;
`endif
endmodule

// File: doc/axis2fib_txwr.md
AXIS2FIB_TXWR -- requirements
Module: axis2fib_txwr

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 64, which is the data path width in bits.
REQ-002 The block SHALL have the parameter BCNT_WIDTH, default 32, which is the width of one byte-count FIFO word.
REQ-003 The block SHALL have the parameter MAX_BYTES, default 16'd9600, which is the maximum frame length in bytes.
REQ-004 The block SHALL have the parameter WF_AFULL_TH, default 10'd256, which is the highest wrusedw_wf at which a new frame may start.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk_fib  in  1  FMAC-domain clock.
- reset_  in  1  asynchronous active-low reset.
REQ-006 The AXI-Stream slave ports SHALL be:
- s_axis_tdata  in  64  frame data, byte 0 in bits [7:0].
- s_axis_tkeep  in  8  byte-valid mask.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  beat accepted when high with tvalid.
REQ-007 The data FIFO ports SHALL be:
- wrfull_wf  in  1  data FIFO full.
- wrusedw_wf  in  10  data FIFO fill level.
- wr_wf  out  1  data FIFO write enable.
- datain_wf  out  64  data FIFO write data.
REQ-008 The byte-count FIFO ports SHALL be:
- wrfull_wcf  in  1  byte-count FIFO full.
- wr_wcf  out  1  byte-count FIFO write enable.
- datain_wcf  out  32  {16'd0, byte_count[15:0]}.
REQ-009 The error ports SHALL be:
- err_clr  in  1  clears sticky errors.
- err_oversize  out  1  sticky: a frame exceeded MAX_BYTES.
- err_tkeep  out  1  sticky: illegal tkeep seen.
REQ-010 The statistics ports SHALL be:
- frame_cnt  out  32  count of frames committed.
- byte_cnt  out  32  count of bytes committed.

Function
REQ-011 The state machine SHALL be one-hot with three states: IDLE=3'b001, DATA=3'b010 and DISCARD=3'b100.
REQ-012 In IDLE, s_axis_tready SHALL be high only when !wrfull_wcf, !wrfull_wf and wrusedw_wf <= WF_AFULL_TH all hold.
REQ-013 In DATA, s_axis_tready SHALL equal !wrfull_wf.
REQ-014 In DISCARD, s_axis_tready SHALL be 1.
REQ-015 A beat SHALL count as accepted only in a cycle where s_axis_tvalid & s_axis_tready is high.
REQ-016 An accepted beat with tkeep != 0 and within the length limit SHALL drive wr_wf=1 and datain_wf=tdata in the next cycle (1-cycle registered latency); wr_wf SHALL be 0 in all other cycles.
REQ-017 Each beat SHALL add popcount(tkeep) (0..8) to a 16-bit running count held per frame; the running count SHALL be cleared when the byte count is written.
REQ-018 err_tkeep SHALL be set when a non-last beat has tkeep != 8'hFF.
REQ-019 err_tkeep SHALL be set when a last beat has a tkeep that is not of the contiguous low-byte form (2^n)-1.
REQ-020 When err_tkeep is set, the beat SHALL still be written and its bytes still counted by popcount.
REQ-021 An accepted beat with tlast in IDLE or DATA SHALL drive wr_wcf=1 with datain_wcf={16'd0, running count including that beat} in the same cycle as that beat's wr_wf, and the state SHALL go to IDLE.
REQ-022 The byte count SHALL never be written before its frame's final data word.
REQ-023 An accepted non-last beat in IDLE SHALL move the state to DATA.
REQ-024 If running count + popcount(tkeep) > MAX_BYTES, the beat SHALL NOT be written, err_oversize SHALL be set, and the count SHALL saturate at the bytes already written.
REQ-025 If that oversize beat has tlast, the count SHALL be written next cycle and the state SHALL go to IDLE; otherwise the state SHALL go to DISCARD.
REQ-026 In DISCARD, beats SHALL be accepted and dropped; on tlast the saturated count SHALL be written next cycle and the state SHALL go to IDLE.
REQ-027 A frame whose final count is 0 (for example a single tlast beat with tkeep=0) SHALL NOT write wcf and SHALL set err_tkeep.
REQ-028 One wcf slot SHALL be guaranteed by the IDLE entry check, so wrfull_wcf SHALL be ignored after a frame has started.
REQ-029 err_clr SHALL clear both sticky error flags; if a set event occurs in the same cycle as err_clr, the set SHALL win.
REQ-030 When the statistics feature is compiled in, frame_cnt SHALL increment by 1 and byte_cnt SHALL increment by the written count on each wcf write, and both SHALL wrap modulo 2^32.

Reset
REQ-031 Asserting reset_ SHALL immediately force the state to IDLE and clear all outputs, the running count, the error flags and the statistics counters to 0.
REQ-032 Reset in the middle of a frame SHALL abandon that frame with no wcf write; the FIFOs are reset by the system alongside this block.

Configuration
REQ-033 When the macro AXIS_TXWR_STATS_EN is defined, frame_cnt and byte_cnt SHALL be implemented as specified in REQ-030.
REQ-034 When AXIS_TXWR_STATS_EN is undefined, frame_cnt and byte_cnt SHALL be tied to 32'd0 and no counter logic SHALL be present.

Verification
REQ-035 A 60-byte frame (7 beats of tkeep FF, last beat tkeep 8'h0F) SHALL produce 8 wr_wf pulses and a wcf write of 32'h0000_003C in the same cycle as the 8th wr_wf.
REQ-036 With wrfull_wf=1 held for 5 cycles mid-frame, tready SHALL be 0 for those cycles, no beat SHALL be lost, and the count SHALL still be correct.
REQ-037 With MAX_BYTES=64 and a 72-byte frame, 8 words SHALL be written, the count SHALL be 64, err_oversize SHALL be 1, and the 9th beat SHALL be dropped.
REQ-038 A non-last beat with tkeep=8'h7F SHALL set err_tkeep; the following err_clr pulse SHALL return it to 0.
REQ-039 With wrusedw_wf=257 in IDLE, tready SHALL be 0; when wrusedw_wf drops to 256, tready SHALL go to 1.
REQ-040 Asserting reset_ after beat 3 of a frame SHALL return all outputs to 0 asynchronously with no wcf write, and the next frame SHALL count from 0; with AXIS_TXWR_STATS_EN defined, 3 frames of 60 bytes SHALL give frame_cnt=3 and byte_cnt=180.
